// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request-side and memory-side bundles for mem_access_ctrl
interface mem_req_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] wdata_in;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] rdata_out;

  modport master (output req, we, addr_in, wdata_in, input busy, done, err, rdata_out);
  modport slave  (input req, we, addr_in, wdata_in, output busy, done, err, rdata_out);
endinterface

interface mem_bus_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_read;
  logic              mem_write;

  modport master (output mem_address, mem_data_in, mem_read, mem_write, input mem_data_out);
  modport slave  (input mem_address, mem_data_in, mem_read, mem_write, output mem_data_out);
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-word initiator for an asynchronous RAM with strobe setup/hold
module mem_access_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_DEPTH   = 512,
  parameter int WAIT_CYCLES = 1
) (
  input  logic      clk,
  input  logic      clr,
  mem_req_if.slave  req_if,
  mem_bus_if.master mem_if
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_HOLD,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_of_range;

  assign out_of_range = {1'b0, req_if.addr_in} >= DEPTH_X;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      rdata_q <= '0;
      op_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      rdata_q <= rdata_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    rdata_d = rdata_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_if.req) begin
          mar_d = req_if.addr_in;
          op_d  = req_if.we;
          if (req_if.we) begin
            mdr_d = req_if.wdata_in;
          end
          state_d = out_of_range ? S_ERR : S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (!op_q) begin
            mdr_d = mem_if.mem_data_out;
          end
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Read result becomes visible together with the done pulse.
        if (!op_q) begin
          rdata_d = mdr_q;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign req_if.busy      = (state_q == S_SETUP) || (state_q == S_ACCESS) || (state_q == S_HOLD);
  assign req_if.done      = (state_q == S_DONE) || (state_q == S_ERR);
  assign req_if.err       = (state_q == S_ERR);
  assign req_if.rdata_out = rdata_q;

  assign mem_if.mem_address = mar_q;
  assign mem_if.mem_data_in = mdr_q;
  assign mem_if.mem_read    = (state_q == S_ACCESS) && !op_q;
  assign mem_if.mem_write   = (state_q == S_ACCESS) && op_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - two controllers (WAIT_CYCLES 1 and 3) against a timeline model
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit loaded = 1'b0;

  logic [31:0] ram     [2][512];
  logic [31:0] exp_mem [2][512];

  // Model: cycles since acceptance (0 = idle) plus the latched request.
  int          mk   [2];
  bit          merr [2];
  bit          mop  [2];
  logic [31:0] mmar [2];
  logic [31:0] mmdr [2];
  logic [31:0] mrd  [2];

  mem_req_if #(.DATA_W(32), .ADDR_W(32)) rq0 ();
  mem_req_if #(.DATA_W(32), .ADDR_W(32)) rq1 ();
  mem_bus_if #(.DATA_W(32), .ADDR_W(32)) mb0 ();
  mem_bus_if #(.DATA_W(32), .ADDR_W(32)) mb1 ();

  assign rq0.req = req;  assign rq0.we = we;  assign rq0.addr_in = addr;  assign rq0.wdata_in = wdata;
  assign rq1.req = req;  assign rq1.we = we;  assign rq1.addr_in = addr;  assign rq1.wdata_in = wdata;
  assign mb0.mem_data_out = ram[0][mb0.mem_address[8:0]];
  assign mb1.mem_data_out = ram[1][mb1.mem_address[8:0]];

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(512), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .clr(clr), .req_if(rq0), .mem_if(mb0));
  mem_access_ctrl #(.DATA_W(32), .ADDR_W(32), .MEM_DEPTH(512), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .clr(clr), .req_if(rq1), .mem_if(mb1));

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    if (i == 43) return 32'd2;
    if (i == 51) return 32'd7;
    if (i == 95) return 32'd13;
    return (i * 32'h0100_0193) ^ 32'h5a5a_1234;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_step(input int d);
    int w;
    w = (d == 0) ? 1 : 3;
    if (clr) begin
      mk[d] = 0; merr[d] = 0; mop[d] = 0; mmar[d] = 0; mmdr[d] = 0; mrd[d] = 0;
    end else if (mk[d] == 0) begin
      if (req) begin
        mk[d] = 1; mmar[d] = addr; mop[d] = we; merr[d] = (addr >= 32'd512);
        if (we) mmdr[d] = wdata;
      end
    end else if (merr[d] || mk[d] == 3 + w) begin
      mk[d] = 0;
    end else begin
      if (mk[d] == 1 + w) begin
        if (mop[d]) exp_mem[d][mmar[d][8:0]] = mmdr[d];
        else        mmdr[d] = exp_mem[d][mmar[d][8:0]];
      end
      if (mk[d] == 2 + w && !mop[d]) mrd[d] = mmdr[d];
      mk[d]++;
    end
  endtask

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) begin
        ram[0][i] <= init_word(i);
        ram[1][i] <= init_word(i);
        exp_mem[0][i] = init_word(i);
        exp_mem[1][i] = init_word(i);
      end
      loaded <= 1'b1;
    end else begin
      if (mb0.mem_write) ram[0][mb0.mem_address[8:0]] <= mb0.mem_data_in;
      if (mb1.mem_write) ram[1][mb1.mem_address[8:0]] <= mb1.mem_data_in;
    end
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int d = 0; d < 2; d++) begin
        int   w, k;
        logic acc, e_busy, e_done, e_err;
        logic a_busy, a_done, a_err, a_rd, a_wr;
        logic [31:0] a_rdata, a_addr, a_din;
        w = (d == 0) ? 1 : 3;
        k = mk[d];
        e_busy = !merr[d] && k >= 1 && k <= 2 + w;
        e_done = (k != 0) && (merr[d] ? (k == 1) : (k == 3 + w));
        e_err  = merr[d] && k == 1;
        acc    = !merr[d] && k >= 2 && k <= 1 + w;
        if (d == 0) begin
          a_busy = rq0.busy; a_done = rq0.done; a_err = rq0.err; a_rdata = rq0.rdata_out;
          a_rd = mb0.mem_read; a_wr = mb0.mem_write; a_addr = mb0.mem_address; a_din = mb0.mem_data_in;
        end else begin
          a_busy = rq1.busy; a_done = rq1.done; a_err = rq1.err; a_rdata = rq1.rdata_out;
          a_rd = mb1.mem_read; a_wr = mb1.mem_write; a_addr = mb1.mem_address; a_din = mb1.mem_data_in;
        end
        chk($sformatf("dut%0d busy", d),        {31'b0, a_busy}, {31'b0, e_busy});
        chk($sformatf("dut%0d done", d),        {31'b0, a_done}, {31'b0, e_done});
        chk($sformatf("dut%0d err", d),         {31'b0, a_err},  {31'b0, e_err});
        chk($sformatf("dut%0d mem_read", d),    {31'b0, a_rd},   {31'b0, acc && !mop[d]});
        chk($sformatf("dut%0d mem_write", d),   {31'b0, a_wr},   {31'b0, acc && mop[d]});
        chk($sformatf("dut%0d mem_address", d), a_addr,  mmar[d]);
        chk($sformatf("dut%0d mem_data_in", d), a_din,   mmdr[d]);
        chk($sformatf("dut%0d rdata_out", d),   a_rdata, mrd[d]);
      end
    end
  end

  int          lat0, lat1;
  logic [31:0] rd0, rd1;
  bit          er0, er1, strobed;

  // Pulse one request while both controllers are idle and collect done timing.
  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] wd);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = wd;
    lat0 = -1; lat1 = -1; rd0 = 'x; rd1 = 'x; er0 = 0; er1 = 0; strobed = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
      if (mb0.mem_read || mb0.mem_write || mb1.mem_read || mb1.mem_write) strobed = 1;
      if (rq0.done && lat0 < 0) begin lat0 = i; rd0 = rq0.rdata_out; er0 = rq0.err; end
      if (rq1.done && lat1 < 0) begin lat1 = i; rd1 = rq1.rdata_out; er1 = rq1.err; end
      if (lat0 > 0 && lat1 > 0) break;
    end
  endtask

  initial begin
    int d0c[$];
    int d1c[$];
    logic [31:0] d0v[$];
    logic [31:0] d1v[$];

    clr = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    cmp_en = 1'b1;
    chk("reset rdata_out", rq0.rdata_out, 32'd0);
    chk("reset busy", {31'b0, rq0.busy}, 32'd0);

    do_req(32'd43, 1'b0, 32'd0);
    chk("read43 latency w1", lat0, 32'd4);
    chk("read43 latency w3", lat1, 32'd6);
    chk("read43 rdata w1", rd0, 32'd2);
    chk("read43 rdata w3", rd1, 32'd2);
    chk("read43 err", {31'b0, er0}, 32'd0);

    do_req(32'h87, 1'b1, 32'hDEADBEEF);
    chk("write latency w1", lat0, 32'd4);
    chk("write latency w3", lat1, 32'd6);
    chk("write keeps rdata", rd0, 32'd2);

    do_req(32'h87, 1'b0, 32'd0);
    chk("readback w1", rd0, 32'hDEADBEEF);
    chk("readback w3", rd1, 32'hDEADBEEF);

    do_req(32'd512, 1'b0, 32'd0);
    chk("oor latency", lat0, 32'd1);
    chk("oor err", {31'b0, er0}, 32'd1);
    chk("oor no strobe", {31'b0, strobed}, 32'd0);
    chk("oor rdata kept", rd0, 32'hDEADBEEF);

    do_req(32'd95, 1'b0, 32'd0);
    chk("read95 latency w3", lat1, 32'd6);
    chk("read95 rdata w3", rd1, 32'd13);

    // Reset while both controllers are in ACCESS of a read.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'd43;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mid access strobe", {31'b0, mb0.mem_read}, 32'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("post clr busy", {31'b0, rq0.busy}, 32'd0);
    chk("post clr done", {31'b0, rq0.done}, 32'd0);
    chk("post clr rdata", rq0.rdata_out, 32'd0);
    req = 1'b1; addr = 32'd51;
    @(negedge clk);
    req = 1'b0;
    chk("accept after clr", {31'b0, rq0.busy}, 32'd1);
    repeat (8) @(negedge clk);

    // Back-to-back reads with req held high.
    req = 1'b1; we = 1'b0; addr = 32'd43;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) addr = 32'd51;
      if (i == 8) req = 1'b0;
      if (rq0.done) begin d0c.push_back(i); d0v.push_back(rq0.rdata_out); end
      if (rq1.done) begin d1c.push_back(i); d1v.push_back(rq1.rdata_out); end
    end
    chk("b2b w1 done count", d0c.size(), 32'd2);
    chk("b2b w3 done count", d1c.size(), 32'd2);
    if (d0c.size() == 2) begin
      chk("b2b w1 first done", d0c[0], 32'd4);
      chk("b2b w1 second done", d0c[1], 32'd9);
      chk("b2b w1 first rdata", d0v[0], 32'd2);
      chk("b2b w1 second rdata", d0v[1], 32'd7);
    end
    if (d1c.size() == 2) begin
      chk("b2b w3 first done", d1c[0], 32'd6);
      chk("b2b w3 second done", d1c[1], 32'd13);
      chk("b2b w3 second rdata", d1v[1], 32'd7);
    end
    repeat (4) @(negedge clk);

    // Random traffic: inputs wiggle while busy, occasional out-of-range and reset.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      req   = ($urandom_range(0, 2) == 0);
      we    = $urandom_range(0, 1) == 1;
      wdata = $urandom;
      case ($urandom_range(0, 15))
        0:       addr = $urandom;
        1:       addr = 32'd512 + $urandom_range(0, 64);
        2:       addr = 32'd511;
        default: addr = $urandom_range(0, 31);
      endcase
      clr = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    clr = 1'b0; req = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
